// File: rtl/data_access_sequencer.sv
// rtl/data_access_sequencer.sv - load/store/fetch sequencer that splits boundary-crossing accesses into bus beats
module data_access_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    bus_valid,
    input  logic                    bus_ready,
    output logic                    bus_write,
    output logic                    bus_instr,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH/8-1:0] bus_byteen,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic                    bus_rvalid,
    input  logic [DATA_WIDTH-1:0]   bus_rdata,
    output logic                    rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic                    busy
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam logic [1:0] OP_INSTR = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [2:0]              size_q, size_d;
    logic                    signed_q, signed_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             result_q, result_d;

    logic [OFFW-1:0]         off;
    logic [3:0]              avail, n0, n1, rm0, rms;
    logic [7:0]              lm0, lm1;
    logic                    split, is_read, beat1;
    logic [ADDR_WIDTH-1:0]   beat0_addr;
    logic [31:0]             ext;

    function automatic logic [31:0] lanes_to_bits(input logic [3:0] m);
        logic [31:0] b;
        for (int j = 0; j < 4; j++) b[8*j +: 8] = {8{m[j]}};
        return b;
    endfunction

    // n0 bytes come from beat0, the remaining n1 from the next bus word
    assign off        = addr_q[OFFW-1:0];
    assign avail      = 4'(BYTES) - 4'(off);
    assign n0         = ({1'b0, size_q} < avail) ? {1'b0, size_q} : avail;
    assign n1         = {1'b0, size_q} - n0;
    assign split      = (n1 != 4'd0);
    assign is_read    = (op_q == OP_INSTR) || (op_q == OP_READ);
    assign lm0        = 8'hFF >> (4'd8 - n0);
    assign lm1        = 8'hFF >> (4'd8 - n1);
    assign rm0        = 4'hF >> (4'd4 - n0);
    assign rms        = 4'hF >> (4'd4 - {1'b0, size_q});
    assign beat0_addr = {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (req_valid && req_ready) begin
                state_d  = (req_op == OP_RSVD) ? RESP : ISSUE0;
                op_d     = req_op;
                signed_d = req_signed;
                wdata_d  = req_wdata;
                result_d = '0;
                case (req_size)
                    2'd0:    size_d = 3'd1;
                    2'd1:    size_d = 3'd2;
                    default: size_d = 3'd4;
                endcase
                addr_d = req_addr;
                if (req_op == OP_INSTR) begin
                    size_d = 3'd4;
                    addr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                end
            end
            ISSUE0: if (bus_ready) state_d = is_read ? WAIT0 : (split ? ISSUE1 : RESP);
            WAIT0: if (bus_rvalid) begin
                state_d  = split ? ISSUE1 : RESP;
                result_d = 32'(bus_rdata >> {off, 3'b000}) & lanes_to_bits(rm0);
            end
            ISSUE1: if (bus_ready) state_d = is_read ? WAIT1 : RESP;
            WAIT1: if (bus_rvalid) begin
                state_d  = RESP;
                result_d = result_q | ((bus_rdata[31:0] << {n0, 3'b000}) & lanes_to_bits(rms));
            end
            RESP: if (enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        beat1      = (state_q == ISSUE1);
        bus_valid  = (state_q == ISSUE0) || beat1;
        bus_write  = bus_valid && (op_q == OP_WRITE);
        bus_instr  = bus_valid && (op_q == OP_INSTR);
        bus_addr   = '0;
        bus_byteen = '0;
        bus_wdata  = '0;
        if (bus_valid) begin
            bus_addr   = beat1 ? beat0_addr + ADDR_WIDTH'(BYTES) : beat0_addr;
            bus_byteen = beat1 ? BYTES'(lm1) : BYTES'(lm0 << off);
            bus_wdata  = beat1 ? DATA_WIDTH'(wdata_q >> {n0, 3'b000})
                               : (DATA_WIDTH'(wdata_q) << {off, 3'b000});
        end
        // instruction fetches are always full 4-byte words and never extended
        ext = result_q;
        if (op_q == OP_READ && signed_q) begin
            if (size_q == 3'd1)      ext = {{24{result_q[7]}}, result_q[7:0]};
            else if (size_q == 3'd2) ext = {{16{result_q[15]}}, result_q[15:0]};
        end
        if (!is_read) ext = '0;
        rsp_valid = (state_q == RESP);
        rsp_rdata = rsp_valid ? ext : '0;
        busy      = (state_q != IDLE);
        req_ready = (state_q == IDLE) && enable && !reset;
    end
endmodule
